// File: rtl/serial_mag_compare.sv
// -----------------------------------------------------------------------------
// serial_mag_compare
//
// Bit-serial, MSB-first magnitude comparator for two WIDTH-bit unsigned
// operands. One bit pair is examined per clock; the first differing bit ends
// the compare early. Equal operands take WIDTH evaluation edges.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst_n   - asynchronous active-low reset
//   en      - global enable; low freezes SHIFT and blocks start in IDLE
//   start   - compare request, accepted only in IDLE with en=1
//   a, b    - operands, captured on the accepted start
//   busy    - high while the compare is in progress (SHIFT)
//   done    - one-cycle pulse; results are valid from here on
//   a_lt_b  - registered result A < B
//   a_gt_b  - registered result A > B
//   a_eq_b  - registered result A == B
// -----------------------------------------------------------------------------
module serial_mag_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT            stateReg;
  logic [WIDTH-1:0] saReg;
  logic [WIDTH-1:0] sbReg;
  logic [CW-1:0]    cntReg;
  logic             ltReg;
  logic             gtReg;
  logic             eqReg;

  // Single-bit compare cell on the current MSBs, gated by en. With en low
  // every relation is 0, so the SHIFT branch below naturally holds all state.
  logic msbA;
  logic msbB;
  logic bitLt;
  logic bitGt;
  logic bitEq;

  assign msbA  = saReg[WIDTH-1];
  assign msbB  = sbReg[WIDTH-1];
  assign bitLt = en & ~msbA &  msbB;
  assign bitGt = en &  msbA & ~msbB;
  assign bitEq = en & ~(msbA ^ msbB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      saReg    <= '0;
      sbReg    <= '0;
      cntReg   <= '0;
      ltReg    <= 1'b0;
      gtReg    <= 1'b0;
      eqReg    <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (start && en) begin
            saReg    <= a;
            sbReg    <= b;
            cntReg   <= CNT_LOAD;
            ltReg    <= 1'b0;
            gtReg    <= 1'b0;
            eqReg    <= 1'b0;
            stateReg <= SHIFT;
          end
        end
        SHIFT: begin
          if (bitLt) begin
            ltReg    <= 1'b1;
            stateReg <= DONE;
          end else if (bitGt) begin
            gtReg    <= 1'b1;
            stateReg <= DONE;
          end else if (bitEq) begin
            if (cntReg == '0) begin
              eqReg    <= 1'b1;
              stateReg <= DONE;
            end else begin
              // Bring the next lower bit pair up to the MSB position.
              saReg  <= {saReg[WIDTH-2:0], 1'b0};
              sbReg  <= {sbReg[WIDTH-2:0], 1'b0};
              cntReg <= cntReg - 1'b1;
            end
          end
        end
        DONE: begin
          // start and en are deliberately ignored here; a new request is
          // only accepted from IDLE on the following cycle.
          stateReg <= IDLE;
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (stateReg == SHIFT);
  assign done   = (stateReg == DONE);
  assign a_lt_b = ltReg;
  assign a_gt_b = gtReg;
  assign a_eq_b = eqReg;

endmodule

// File: tb/tb_serial_mag_compare.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_compare
//
// Directed, table-driven bench for serial_mag_compare (WIDTH = 8). Each table
// record holds the operands, the expected one-hot result {lt,gt,eq}, the
// expected number of edges from the accepting edge to done, an optional
// enable stall and a protocol-abuse flag. Multi-cycle corner cases (reset
// during SHIFT, start with en low) are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_serial_mag_compare;

  localparam int WIDTH = 8;
  localparam int NVEC  = 10;
  localparam int NONE  = 99;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_lt_b;
  logic             a_gt_b;
  logic             a_eq_b;

  serial_mag_compare #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .a_lt_b (a_lt_b),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [2:0] res;      // {lt, gt, eq}
    int         lat;      // edges from accept to done
    int         stallAt;  // edge index at which en starts low
    int         stallLen; // number of edges with en low
    bit         abuse;    // wiggle a/b/start while busy and in DONE
  } vecT;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  vecT vecs [NVEC];
  int  nVec  = 0;
  int  nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doVec(input int i);
    vecT v;
    int  edges;
    int  busyCnt;
    bit  seen;
    v = vecs[i];
    @(negedge clk);
    a = v.va; b = v.vb; start = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    check($sformatf("v%0d accept busy", i), busy, 1);
    check($sformatf("v%0d results cleared", i), {a_lt_b, a_gt_b, a_eq_b}, 0);
    edges   = 0;
    busyCnt = busy ? 1 : 0;
    seen    = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      start = v.abuse;
      if (v.abuse) begin
        a = ~v.va;
        b = v.va ^ 8'h5A;
      end
      en = !(edges >= v.stallAt && edges < v.stallAt + v.stallLen);
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
      else if (busy) busyCnt++;
    end
    if (!seen) edges = -1;
    $display("vec %0d: a=%h b=%h -> lt/gt/eq=%b after %0d edges", i, v.va, v.vb,
             {a_lt_b, a_gt_b, a_eq_b}, edges);
    check($sformatf("v%0d latency", i), edges, v.lat);
    check($sformatf("v%0d busy cycles", i), busyCnt, v.lat);
    check($sformatf("v%0d result", i), {a_lt_b, a_gt_b, a_eq_b}, v.res);
    // Cycle after DONE: done must drop, start in DONE dropped, en ignored.
    @(negedge clk);
    start = v.abuse;
    en    = !v.abuse;
    @(posedge clk); #1;
    check($sformatf("v%0d done pulse", i), {busy, done}, 0);
    check($sformatf("v%0d result held", i), {a_lt_b, a_gt_b, a_eq_b}, v.res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int doneSeen;

    vecs[0] = '{8'h80, 8'h7F, GT, 1, NONE, 0, 1'b0};
    vecs[1] = '{8'h54, 8'h55, LT, 8, NONE, 0, 1'b0};
    vecs[2] = '{8'hA5, 8'hA5, EQ, 8, NONE, 0, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, LT, 1, NONE, 0, 1'b0};
    vecs[4] = '{8'h40, 8'h20, GT, 2, NONE, 0, 1'b0};
    vecs[5] = '{8'h0F, 8'h0E, GT, 11, 2, 3, 1'b0};
    vecs[6] = '{8'h3C, 8'h3C, EQ, 8, NONE, 0, 1'b1};
    vecs[7] = '{8'h12, 8'h13, LT, 8, NONE, 0, 1'b0};
    vecs[8] = '{8'hC3, 8'hC1, GT, 7, NONE, 0, 1'b1};
    vecs[9] = '{8'h00, 8'h00, EQ, 8, NONE, 0, 1'b0};

    rst_n = 1'b0; en = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {busy, done, a_lt_b, a_gt_b, a_eq_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) doVec(i);
    @(negedge clk);
    start = 1'b0; en = 1'b1;

    // Reset in the middle of SHIFT: outputs clear asynchronously, no done.
    @(negedge clk);
    a = 8'hF0; b = 8'hF1; start = 1'b1; en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy before mid reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {busy, done, a_lt_b, a_gt_b, a_eq_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy) doneSeen++;
    end
    $display("reset mid-shift: busy/done seen %0d times after release", doneSeen);
    check("no done after reset", doneSeen, 0);

    // start with en low in IDLE is not accepted.
    @(negedge clk);
    a = 8'h01; b = 8'h02; en = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("en0 start busy %0d", k), {busy, done}, 0);
    end
    @(negedge clk);
    start = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    $display("start with en=0: busy=%b done=%b", busy, done);
    check("en0 no late accept", {busy, done, a_lt_b, a_gt_b, a_eq_b}, 0);

    // Normal compare after the reset sequence.
    doVec(1);
    doVec(0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/serial_mag_compare.md
Name: serial_mag_compare

Overview:
- Bit-serial, MSB-first magnitude comparator for two WIDTH-bit unsigned operands.
- Evaluates one bit per clock, using the single-bit less-than / greater-than / equal relation with enable gating of the team's combinational compare cell.
- Chains that per-bit relation over time, exits early on the first differing bit, and reports a registered result with a done pulse.
- Sits between an operand producer (start/a/b) and any consumer that needs a multi-bit ordering result without a wide parallel comparator.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- en  input  1  global enable; low freezes evaluation and blocks start.
- start  input  1  request a compare; sampled only in IDLE with en=1.
- a  input  WIDTH  operand A, captured on the accepted start.
- b  input  WIDTH  operand B, captured on the accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result valid while high and held afterwards.
- a_lt_b  output  1  registered result A < B.
- a_gt_b  output  1  registered result A > B.
- a_eq_b  output  1  registered result A == B.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values (async, mid-operation included):
  - State = IDLE.
  - busy, done, a_lt_b, a_gt_b and a_eq_b are all 0.
  - Shift registers and the counter are 0.
  - An in-flight compare is discarded; no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 and en=1: capture a/b into shift registers sa/sb, load counter = WIDTH-1, clear all three result outputs, go to SHIFT.
  - If start=1 and en=0: ignored.
- SHIFT, when en=1, each edge compares sa[WIDTH-1] and sb[WIDTH-1]:
  - sa=0, sb=1: a_lt_b <= 1, go to DONE.
  - sa=1, sb=0: a_gt_b <= 1, go to DONE.
  - Bits equal and counter = 0: a_eq_b <= 1, go to DONE.
  - Bits equal and counter != 0: shift sa/sb left by 1 (zero-fill), decrement counter, stay in SHIFT.
- SHIFT, when en=0: registers, counter and state all hold; busy stays 1.
- DONE:
  - done=1 for exactly one cycle, then unconditionally to IDLE.
  - en is ignored in DONE.
  - start is ignored in DONE (earliest new accept is the cycle after DONE).
- Outputs:
  - busy = (state==SHIFT); done = (state==DONE). Both are Moore outputs.
  - Results are one-hot once set.
  - Results hold their value from DONE until the next accepted start, which clears them to 000.
- Latency, with en held high and the first differing bit at position p (MSB = WIDTH-1):
  - done is high in the cycle following the (WIDTH-p)-th rising edge after the start-accepting edge.
  - Equal operands take WIDTH edges.
  - Each en=0 cycle in SHIFT adds exactly one cycle.
- start, a and b while busy or in DONE are ignored. The captured operands are unaffected by later changes on a/b.
- Simultaneous events:
  - Reset overrides everything.
  - A start arriving in the same cycle as DONE is dropped; the producer must re-assert it.

Test Plan:
- Reset mid-SHIFT: start a=8'hF0, b=8'hF1, pull rst_n low after 3 edges -> all outputs 0 asynchronously; no done afterwards; a later start runs normally.
- MSB differs: a=8'h80, b=8'h7F, start with en=1 -> done after 1 edge, a_gt_b=1, a_lt_b=0, a_eq_b=0, busy high 1 cycle.
- LSB differs: a=8'h54, b=8'h55 -> done after 8 edges, a_lt_b=1; then a=b=8'hA5 -> done after 8 edges, a_eq_b=1; results hold 000-free until the next start clears them.
- Enable stall: a=8'h0F, b=8'h0E, drop en for 3 cycles mid-SHIFT -> done after 8+3 edges, a_gt_b=1; start with en=0 in IDLE -> no accept, busy stays 0.
- Protocol abuse: change a/b and pulse start while busy, and pulse start in the DONE cycle -> the original result is unaffected and no second compare starts; a start one cycle after DONE is accepted.
